// File: rtl/uart_rx_out_fifo_pkg.sv
// Shared UART definitions: default word width and a constant-foldable clog2
// used to size pointers and occupancy counters.
package uart_rx_out_fifo_pkg;

  localparam int unsigned UART_WIDTH = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_out_fifo.sv
// UART receive output stage: DEPTH-entry first-word-fall-through FIFO with a
// sticky overrun flag and hold-last-word output when empty.
module uart_rx_out_fifo
  import uart_rx_out_fifo_pkg::*;
#(
  parameter  int unsigned WIDTH = UART_WIDTH,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Out_rdy,
  input  logic [WIDTH-1:0] Data_Out,
  input  logic             Rd_en,
  input  logic             Ovr_clr,
  output logic [WIDTH-1:0] Data_Out_FPGA,
  output logic             Data_valid,
  output logic             Fifo_full,
  output logic [CW-1:0]    Count,
  output logic             Overrun
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] last_word;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
    pop   = Rd_en && !empty;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    push  = Out_rdy && (!full || pop);
  end

  // Storage carries no reset; its contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Data_Out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= '0;
      Overrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_word <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (Out_rdy && full && !pop) Overrun <= 1'b1;
      else if (Ovr_clr)            Overrun <= 1'b0;
    end
  end

  always_comb begin
    Data_valid    = !empty;
    Fifo_full     = full;
    Count         = count;
    Data_Out_FPGA = empty ? last_word : mem[rd_ptr];
  end

endmodule

// File: doc/uart_rx_out_fifo.md
Name: uart_rx_out_fifo

Overview:
Parametrised successor to the single-register UART receive output stage. It buffers received bytes in a DEPTH-entry first-word-fall-through FIFO between the UART receiver (Out_rdy/Data_Out) and FPGA-side logic. Consumers pop with a valid/read handshake. The block flags overrun when bytes arrive faster than they are consumed. When empty, the last consumed byte stays on the output, preserving the hold behaviour of the previous generation.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 4, FIFO entries; power of two, >= 2
CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
Out_rdy  in  1  write strobe from UART receiver, one cycle per received word
Data_Out  in  WIDTH  received word, sampled when Out_rdy=1
Rd_en  in  1  consumer pop request
Ovr_clr  in  1  clears sticky Overrun flag
Data_Out_FPGA  out  WIDTH  head of FIFO when non-empty; last popped word when empty
Data_valid  out  1  FIFO non-empty
Fifo_full  out  1  occupancy == DEPTH
Count  out  CW  current occupancy, 0..DEPTH
Overrun  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (rst_n=0, async assert, sync-safe release): wr_ptr=rd_ptr=0, Count=0, Data_valid=0, Fifo_full=0, Overrun=0, last-word register=0, so Data_Out_FPGA=0. Storage contents are don't-care.
- Reset mid-operation discards all buffered words immediately. No partial pops or pushes are completed.
- Push: occurs when Out_rdy=1 and (Count<DEPTH or pop in the same cycle). The word is written at mem[wr_ptr], and wr_ptr increments modulo DEPTH, wrapping naturally at the power-of-two depth.
- Pop: occurs when Rd_en=1 and Count>0. mem[rd_ptr] is copied to the last-word register, and rd_ptr increments modulo DEPTH.
- Rd_en while empty is ignored: no state change, no underflow.
- Latency: a word pushed at edge N drives Data_Out_FPGA with Data_valid=1 from after edge N, when the FIFO was empty (one-cycle write-to-visible). The output is combinational from mem[rd_ptr] while Count>0. It must be glitch-free relative to clk, and no path runs from Out_rdy to outputs within a cycle.
- Simultaneous push+pop:
  - Count>0: Count is unchanged, both pointers advance.
  - Full: the push is accepted, with no overrun.
  - Empty: only the push takes effect, because the pop is ignored.
- Count update: +1 on push only, -1 on pop only, otherwise unchanged. Fifo_full=(Count==DEPTH) and Data_valid=(Count!=0), both derived from Count. No other registered copies exist.
- Overrun: set on any edge where Out_rdy=1, Count==DEPTH, and no valid pop occurs. The incoming word is dropped, and FIFO contents and pointers are untouched.
  - Overrun stays set until an edge with Ovr_clr=1.
  - If set and clear coincide, set wins.
- Empty hold: when Count==0, Data_Out_FPGA = last-word register. This register changes only on a pop.
- No combinational path from Rd_en to Data_Out_FPGA other than through registers.

Decomposition:
- A shared uart package holds the default UART word width constant (8) and a clog2 helper function, used by CW and by other UART blocks.
- No sub-module is required. Pointer/count logic and storage stay in one module of roughly 150 lines.

Test Plan:
1. Reset then single byte: assert rst_n=0, release, push 0xA5 -> Data_valid=1, Data_Out_FPGA=0xA5, Count=1 on the next cycle. Pop -> Data_valid=0, Data_Out_FPGA holds 0xA5.
2. Fill and wrap: push 0x01..0x04 (DEPTH=4) -> Fifo_full=1, Count=4. Pop all four -> outputs 0x01,0x02,0x03,0x04 in order. Push 0x05..0x06 -> pointers wrap, order preserved.
3. Overrun: FIFO full with 0x10..0x13, push 0x14 without Rd_en -> Overrun=1, Count=4, 0x14 never appears. Assert Ovr_clr -> Overrun=0. Assert Ovr_clr concurrent with a new overrun -> Overrun stays 1.
4. Simultaneous push+pop: when full, push 0x20 with Rd_en -> no overrun, Count=4, head advances. When empty, push 0x30 with Rd_en -> Count=1, Data_Out_FPGA=0x30.
5. Underflow guard: Rd_en held for 5 cycles while empty -> Count=0, pointers unchanged, Data_Out_FPGA holds the previous last word.
6. Async reset mid-stream: with Count=3 and Overrun=1, pulse rst_n low between clock edges -> all outputs return to reset values immediately, without waiting for clk.
